// File: rtl/pcie_mon_pkg.sv
// Shared symbol constants, TS field offsets and lane state type for the ordered-set monitor.
package pcie_mon_pkg;

  // K-symbol codes
  localparam logic [7:0] COM = 8'hBC;
  localparam logic [7:0] PAD = 8'hF7;
  localparam logic [7:0] SKP = 8'h1C;
  localparam logic [7:0] FTS = 8'h3C;
  localparam logic [7:0] IDL = 8'h7C;

  // TS identifier data symbols
  localparam logic [7:0] TS1_ID = 8'h4A;
  localparam logic [7:0] TS2_ID = 8'h45;

  // Symbol offsets within a TS, counted from COM = 0
  localparam logic [3:0] TSX_LINKNUM     = 4'd1;
  localparam logic [3:0] TSX_LANENUM     = 4'd2;
  localparam logic [3:0] TSX_N_FTS       = 4'd3;
  localparam logic [3:0] TSX_DATARATE    = 4'd4;
  localparam logic [3:0] TSX_LINKCONTROL = 4'd5;
  localparam logic [3:0] TSX_ID          = 4'd6;
  localparam logic [3:0] TSX_LAST        = 4'd15;

  typedef enum logic [1:0] {
    StHunt,
    StTsBody,
    StSkpBody,
    StEiBody
  } lane_state_e;

endpackage

// File: rtl/pcie_os_lane_fsm.sv
// Single-lane ordered-set delineator: TS/SKP/FTS/EIOS recognition, TS field capture,
// error pulses and a saturating error counter.
module pcie_os_lane_fsm
  import pcie_mon_pkg::*;
#(
  parameter int unsigned CNT_W   = 8,
  parameter int unsigned CHECK_X = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             enable,
  input  logic [7:0]       sym,
  input  logic             is_k,
  output logic             ts_valid,
  output logic             ts_is_ts2,
  output logic [7:0]       link_num,
  output logic [7:0]       lane_num,
  output logic [7:0]       n_fts,
  output logic [7:0]       rate,
  output logic [7:0]       ctrl,
  output logic             skp_seen,
  output logic             fts_seen,
  output logic             eios_seen,
  output logic             seen_os,
  output logic             os_err,
  output logic             x_err,
  output logic [CNT_W-1:0] err_count
);

  lane_state_e state_q, state_d;
  logic [3:0]  idx_q, idx_d;

  // Shadow copies filled while the TS body streams in; published together on completion
  logic [7:0] sh_link_q, sh_link_d;
  logic [7:0] sh_lane_q, sh_lane_d;
  logic [7:0] sh_nfts_q, sh_nfts_d;
  logic [7:0] sh_rate_q, sh_rate_d;
  logic [7:0] sh_ctrl_q, sh_ctrl_d;
  logic [7:0] sh_id_q, sh_id_d;

  logic ts_valid_q, ts_is_ts2_q, skp_seen_q, fts_seen_q, eios_seen_q;
  logic seen_os_q, os_err_q, x_err_q;
  logic [7:0] link_num_q, lane_num_q, n_fts_q, rate_q, ctrl_q;
  logic [CNT_W-1:0] err_count_q;

  logic is_com, ts_sym_ok;
  logic ts_fire, skp_fire, fts_fire, eios_fire, err_fire, x_fire, seen_set;

  assign is_com = is_k && (sym == COM);

  // Legality of the current symbol at its position inside a TS body
  always_comb begin
    ts_sym_ok = 1'b0;
    if (idx_q == TSX_LANENUM) begin
      ts_sym_ok = !is_k || (sym == PAD);
    end else if (idx_q < TSX_ID) begin
      ts_sym_ok = !is_k;
    end else if (idx_q == TSX_ID) begin
      ts_sym_ok = !is_k && ((sym == TS1_ID) || (sym == TS2_ID));
    end else begin
      ts_sym_ok = !is_k && (sym == sh_id_q);
    end
  end

  // Next-state, field capture and event decisions for one symbol
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    sh_link_d = sh_link_q;
    sh_lane_d = sh_lane_q;
    sh_nfts_d = sh_nfts_q;
    sh_rate_d = sh_rate_q;
    sh_ctrl_d = sh_ctrl_q;
    sh_id_d   = sh_id_q;
    ts_fire   = 1'b0;
    skp_fire  = 1'b0;
    fts_fire  = 1'b0;
    eios_fire = 1'b0;
    err_fire  = 1'b0;
    x_fire    = 1'b0;
    seen_set  = 1'b0;

    // X only resolves in a four-state simulator; it overrides any OS decision
    if ((CHECK_X != 0) && seen_os_q && $isunknown(sym)) begin
      x_fire  = 1'b1;
      state_d = StHunt;
      idx_d   = 4'd0;
    end else if (idx_q == TSX_LINKNUM) begin
      // Symbol right after COM selects the ordered-set type, whatever state we came from
      if (is_com) begin
        state_d = StHunt;
        idx_d   = 4'd1;
      end else if (is_k && (sym == SKP)) begin
        state_d = StSkpBody;
        idx_d   = 4'd2;
      end else if (is_k && (sym == FTS)) begin
        fts_fire = 1'b1;
        seen_set = 1'b1;
        state_d  = StHunt;
        idx_d    = 4'd0;
      end else if (is_k && (sym == IDL)) begin
        state_d = StEiBody;
        idx_d   = 4'd2;
      end else if (!is_k || (sym == PAD)) begin
        state_d   = StTsBody;
        idx_d     = 4'd2;
        sh_link_d = sym;
      end else begin
        err_fire = 1'b1;
        state_d  = StHunt;
        idx_d    = 4'd0;
      end
    end else begin
      unique case (state_q)
        StHunt: begin
          if (is_com) idx_d = 4'd1;
        end
        StTsBody: begin
          if (is_com) begin
            err_fire = 1'b1;
            idx_d    = 4'd1;
          end else if (!ts_sym_ok) begin
            err_fire = 1'b1;
            state_d  = StHunt;
            idx_d    = 4'd0;
          end else begin
            case (idx_q)
              TSX_LANENUM:     sh_lane_d = sym;
              TSX_N_FTS:       sh_nfts_d = sym;
              TSX_DATARATE:    sh_rate_d = sym;
              TSX_LINKCONTROL: sh_ctrl_d = sym;
              TSX_ID:          sh_id_d   = sym;
              default:         ;
            endcase
            if (idx_q == TSX_LAST) begin
              ts_fire  = 1'b1;
              seen_set = 1'b1;
              state_d  = StHunt;
              idx_d    = 4'd0;
            end else begin
              idx_d = idx_q + 4'd1;
            end
          end
        end
        StSkpBody, StEiBody: begin
          if (is_com) begin
            err_fire = 1'b1;
            idx_d    = 4'd1;
          end else if (is_k && (sym == ((state_q == StSkpBody) ? SKP : IDL))) begin
            if (idx_q == 4'd3) begin
              skp_fire  = (state_q == StSkpBody);
              eios_fire = (state_q == StEiBody);
              seen_set  = (state_q == StSkpBody);
              state_d   = StHunt;
              idx_d     = 4'd0;
            end else begin
              idx_d = idx_q + 4'd1;
            end
          end else begin
            err_fire = 1'b1;
            state_d  = StHunt;
            idx_d    = 4'd0;
          end
        end
        default: begin
          state_d = StHunt;
          idx_d   = 4'd0;
        end
      endcase
    end
  end

  // State, shadow, published fields, pulses and counter; everything holds while disabled
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= StHunt;
      idx_q       <= 4'd0;
      sh_link_q   <= 8'h00;
      sh_lane_q   <= 8'h00;
      sh_nfts_q   <= 8'h00;
      sh_rate_q   <= 8'h00;
      sh_ctrl_q   <= 8'h00;
      sh_id_q     <= 8'h00;
      ts_valid_q  <= 1'b0;
      ts_is_ts2_q <= 1'b0;
      link_num_q  <= 8'h00;
      lane_num_q  <= 8'h00;
      n_fts_q     <= 8'h00;
      rate_q      <= 8'h00;
      ctrl_q      <= 8'h00;
      skp_seen_q  <= 1'b0;
      fts_seen_q  <= 1'b0;
      eios_seen_q <= 1'b0;
      seen_os_q   <= 1'b0;
      os_err_q    <= 1'b0;
      x_err_q     <= 1'b0;
      err_count_q <= '0;
    end else if (enable) begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      sh_link_q   <= sh_link_d;
      sh_lane_q   <= sh_lane_d;
      sh_nfts_q   <= sh_nfts_d;
      sh_rate_q   <= sh_rate_d;
      sh_ctrl_q   <= sh_ctrl_d;
      sh_id_q     <= sh_id_d;
      ts_valid_q  <= ts_fire;
      skp_seen_q  <= skp_fire;
      fts_seen_q  <= fts_fire;
      eios_seen_q <= eios_fire;
      os_err_q    <= err_fire;
      x_err_q     <= x_fire;
      if (ts_fire) begin
        link_num_q  <= sh_link_q;
        lane_num_q  <= sh_lane_q;
        n_fts_q     <= sh_nfts_q;
        rate_q      <= sh_rate_q;
        ctrl_q      <= sh_ctrl_q;
        ts_is_ts2_q <= (sh_id_q == TS2_ID);
      end
      if (x_fire) begin
        seen_os_q <= 1'b0;
      end else if (seen_set) begin
        seen_os_q <= 1'b1;
      end
      if ((err_fire || x_fire) && (err_count_q != '1)) begin
        err_count_q <= err_count_q + CNT_W'(1);
      end
    end else begin
      ts_valid_q  <= 1'b0;
      skp_seen_q  <= 1'b0;
      fts_seen_q  <= 1'b0;
      eios_seen_q <= 1'b0;
      os_err_q    <= 1'b0;
      x_err_q     <= 1'b0;
    end
  end

  assign ts_valid  = ts_valid_q;
  assign ts_is_ts2 = ts_is_ts2_q;
  assign link_num  = link_num_q;
  assign lane_num  = lane_num_q;
  assign n_fts     = n_fts_q;
  assign rate      = rate_q;
  assign ctrl      = ctrl_q;
  assign skp_seen  = skp_seen_q;
  assign fts_seen  = fts_seen_q;
  assign eios_seen = eios_seen_q;
  assign seen_os   = seen_os_q;
  assign os_err    = os_err_q;
  assign x_err     = x_err_q;
  assign err_count = err_count_q;

endmodule

// File: rtl/pcie_ts_lane_monitor.sv
// Multi-lane Gen1/Gen2 ordered-set monitor: per-lane delineators plus a cross-lane
// link-number comparator.
module pcie_ts_lane_monitor
  import pcie_mon_pkg::*;
#(
  parameter int unsigned NUM_LANES = 16,
  parameter int unsigned CNT_W     = 8,
  parameter int unsigned CHECK_X   = 1
) (
  input  logic                       Clk,
  input  logic                       notReset,
  input  logic                       Enable,
  input  logic [8*NUM_LANES-1:0]     RxByte,
  input  logic [NUM_LANES-1:0]       RxControl,
  output logic [NUM_LANES-1:0]       TsValid,
  output logic [NUM_LANES-1:0]       TsIsTs2,
  output logic [8*NUM_LANES-1:0]     TsLinkNum,
  output logic [8*NUM_LANES-1:0]     TsLaneNum,
  output logic [8*NUM_LANES-1:0]     TsNfts,
  output logic [8*NUM_LANES-1:0]     TsRate,
  output logic [8*NUM_LANES-1:0]     TsCtrl,
  output logic [NUM_LANES-1:0]       SkpSeen,
  output logic [NUM_LANES-1:0]       FtsSeen,
  output logic [NUM_LANES-1:0]       EiosSeen,
  output logic [NUM_LANES-1:0]       SeenOS,
  output logic [NUM_LANES-1:0]       OsErr,
  output logic [NUM_LANES-1:0]       XErr,
  output logic                       LinkMismatch,
  output logic [CNT_W*NUM_LANES-1:0] ErrCount
);

  for (genvar n = 0; n < NUM_LANES; n++) begin : g_lane
    pcie_os_lane_fsm #(
      .CNT_W   (CNT_W),
      .CHECK_X (CHECK_X)
    ) u_lane (
      .clk       (Clk),
      .rst_n     (notReset),
      .enable    (Enable),
      .sym       (RxByte[8*n +: 8]),
      .is_k      (RxControl[n]),
      .ts_valid  (TsValid[n]),
      .ts_is_ts2 (TsIsTs2[n]),
      .link_num  (TsLinkNum[8*n +: 8]),
      .lane_num  (TsLaneNum[8*n +: 8]),
      .n_fts     (TsNfts[8*n +: 8]),
      .rate      (TsRate[8*n +: 8]),
      .ctrl      (TsCtrl[8*n +: 8]),
      .skp_seen  (SkpSeen[n]),
      .fts_seen  (FtsSeen[n]),
      .eios_seen (EiosSeen[n]),
      .seen_os   (SeenOS[n]),
      .os_err    (OsErr[n]),
      .x_err     (XErr[n]),
      .err_count (ErrCount[CNT_W*n +: CNT_W])
    );
  end

  logic       mism;
  logic       have_ref;
  logic [7:0] ref_link;

  // Any two simultaneously published non-PAD link numbers that disagree
  always_comb begin
    mism     = 1'b0;
    have_ref = 1'b0;
    ref_link = 8'h00;
    for (int n = 0; n < int'(NUM_LANES); n++) begin
      if (TsValid[n] && (TsLinkNum[8*n +: 8] != PAD)) begin
        if (have_ref && (TsLinkNum[8*n +: 8] != ref_link)) mism = 1'b1;
        if (!have_ref) begin
          have_ref = 1'b1;
          ref_link = TsLinkNum[8*n +: 8];
        end
      end
    end
  end

  // Mismatch is reported one cycle after the fields it compares are published
  always_ff @(posedge Clk) begin
    if (!notReset) begin
      LinkMismatch <= 1'b0;
    end else begin
      LinkMismatch <= Enable && mism;
    end
  end

endmodule

// File: tb/tb_pcie_ts_lane_monitor.sv
// Scoreboard bench for pcie_ts_lane_monitor: stimulus queues expected events with their
// cycle, a negedge monitor pops and compares each pulse the DUT raises.
module tb_pcie_ts_lane_monitor;

  localparam int NL   = 4;
  localparam int CW   = 2;
  localparam int MAXS = 48;

  localparam int K_TS   = 0;
  localparam int K_SKP  = 1;
  localparam int K_FTS  = 2;
  localparam int K_EIOS = 3;
  localparam int K_OERR = 4;
  localparam int K_XERR = 5;
  localparam int K_MISM = 6;

  logic              Clk = 1'b0;
  logic              notReset;
  logic              Enable;
  logic [8*NL-1:0]   RxByte;
  logic [NL-1:0]     RxControl;
  logic [NL-1:0]     TsValid, TsIsTs2, SkpSeen, FtsSeen, EiosSeen, SeenOS, OsErr, XErr;
  logic [8*NL-1:0]   TsLinkNum, TsLaneNum, TsNfts, TsRate, TsCtrl;
  logic              LinkMismatch;
  logic [CW*NL-1:0]  ErrCount;

  pcie_ts_lane_monitor #(
    .NUM_LANES (NL),
    .CNT_W     (CW),
    .CHECK_X   (1)
  ) dut (
    .Clk          (Clk),
    .notReset     (notReset),
    .Enable       (Enable),
    .RxByte       (RxByte),
    .RxControl    (RxControl),
    .TsValid      (TsValid),
    .TsIsTs2      (TsIsTs2),
    .TsLinkNum    (TsLinkNum),
    .TsLaneNum    (TsLaneNum),
    .TsNfts       (TsNfts),
    .TsRate       (TsRate),
    .TsCtrl       (TsCtrl),
    .SkpSeen      (SkpSeen),
    .FtsSeen      (FtsSeen),
    .EiosSeen     (EiosSeen),
    .SeenOS       (SeenOS),
    .OsErr        (OsErr),
    .XErr         (XErr),
    .LinkMismatch (LinkMismatch),
    .ErrCount     (ErrCount)
  );

  always #5 Clk = ~Clk;

  int cyc = 0;
  always @(posedge Clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_err = 0;

  typedef struct {
    int            kind;
    int            lane;
    int            cyc;
    logic [7:0]    link;
    logic [7:0]    lanen;
    logic [7:0]    nfts;
    logic          ts2;
    logic [CW-1:0] cnt;
    logic          seen;
  } ev_t;

  ev_t exp_q[$];

  logic [7:0] sb [NL][MAXS];
  logic       sk [NL][MAXS];
  logic       se [MAXS];

  function automatic string kname(input int kind);
    case (kind)
      K_TS:    return "TsValid";
      K_SKP:   return "SkpSeen";
      K_FTS:   return "FtsSeen";
      K_EIOS:  return "EiosSeen";
      K_OERR:  return "OsErr";
      K_XERR:  return "XErr";
      default: return "LinkMismatch";
    endcase
  endfunction

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, required %h", name, got, exp);
    end
  endtask

  task automatic push_ts(input int lane, input int c, input logic [7:0] link,
                         input logic [7:0] lanen, input logic [7:0] nfts, input logic ts2);
    ev_t e;
    e.kind = K_TS; e.lane = lane; e.cyc = c; e.link = link; e.lanen = lanen;
    e.nfts = nfts; e.ts2 = ts2; e.cnt = '0; e.seen = 1'b1;
    exp_q.push_back(e);
  endtask

  task automatic push_ev(input int kind, input int lane, input int c,
                         input logic [CW-1:0] cnt, input logic seen);
    ev_t e;
    e.kind = kind; e.lane = lane; e.cyc = c; e.link = 8'h00; e.lanen = 8'h00;
    e.nfts = 8'h00; e.ts2 = 1'b0; e.cnt = cnt; e.seen = seen;
    exp_q.push_back(e);
  endtask

  // Pop the oldest matching expectation and compare timing plus relevant fields
  task automatic check_ev(input int kind, input int lane);
    int   idx;
    ev_t  e;
    logic ok;
    idx = -1;
    foreach (exp_q[i]) begin
      if (idx < 0 && exp_q[i].kind == kind && exp_q[i].lane == lane) idx = i;
    end
    n_cmp++;
    if (idx < 0) begin
      n_err++;
      $display("FAIL unexpected %s lane %0d at cycle %0d: got pulse, required none",
               kname(kind), lane, cyc);
    end else begin
      e = exp_q[idx];
      exp_q.delete(idx);
      ok = (e.cyc == cyc);
      if (kind == K_TS) begin
        ok = ok && (TsLinkNum[8*lane +: 8] == e.link) && (TsLaneNum[8*lane +: 8] == e.lanen)
                && (TsNfts[8*lane +: 8] == e.nfts) && (TsRate[8*lane +: 8] == 8'h02)
                && (TsCtrl[8*lane +: 8] == 8'h00) && (TsIsTs2[lane] == e.ts2);
      end
      if (kind == K_OERR || kind == K_XERR) ok = ok && (ErrCount[CW*lane +: CW] == e.cnt);
      if (kind == K_XERR || kind == K_SKP || kind == K_FTS) ok = ok && (SeenOS[lane] == e.seen);
      if (!ok) begin
        n_err++;
        $display("FAIL %s lane %0d: got cyc %0d link %h lane %h nfts %h rate %h ctrl %h ts2 %b cnt %0d seen %b, required cyc %0d link %h lane %h nfts %h rate 02 ctrl 00 ts2 %b cnt %0d seen %b",
                 kname(kind), lane, cyc, TsLinkNum[8*lane +: 8], TsLaneNum[8*lane +: 8],
                 TsNfts[8*lane +: 8], TsRate[8*lane +: 8], TsCtrl[8*lane +: 8], TsIsTs2[lane],
                 ErrCount[CW*lane +: CW], SeenOS[lane], e.cyc, e.link, e.lanen, e.nfts, e.ts2,
                 e.cnt, e.seen);
      end
    end
  endtask

  always @(negedge Clk) begin
    if (notReset === 1'b1) begin
      for (int l = 0; l < NL; l++) begin
        if (TsValid[l])  check_ev(K_TS, l);
        if (SkpSeen[l])  check_ev(K_SKP, l);
        if (FtsSeen[l])  check_ev(K_FTS, l);
        if (EiosSeen[l]) check_ev(K_EIOS, l);
        if (OsErr[l])    check_ev(K_OERR, l);
        if (XErr[l])     check_ev(K_XERR, l);
      end
      if (LinkMismatch) check_ev(K_MISM, 0);
    end
  end

  task automatic clear_seq();
    for (int p = 0; p < MAXS; p++) begin
      se[p] = 1'b1;
      for (int l = 0; l < NL; l++) begin
        sb[l][p] = 8'h00;
        sk[l][p] = 1'b0;
      end
    end
  endtask

  task automatic put(input int l, input int p, input logic [7:0] b, input logic k);
    sb[l][p] = b;
    sk[l][p] = k;
  endtask

  task automatic put_ts(input int l, input int p, input logic [7:0] link, input logic lk,
                        input logic [7:0] lanen, input logic lnk, input logic [7:0] nfts,
                        input logic [7:0] id);
    put(l, p, 8'hBC, 1'b1);
    put(l, p + 1, link, lk);
    put(l, p + 2, lanen, lnk);
    put(l, p + 3, nfts, 1'b0);
    put(l, p + 4, 8'h02, 1'b0);
    put(l, p + 5, 8'h00, 1'b0);
    for (int i = 6; i < 16; i++) put(l, p + i, id, 1'b0);
  endtask

  // Symbol i is presented at cycle start+i; its registered response shows at start+i+1
  task automatic run_seq(input int n);
    for (int i = 0; i < n; i++) begin
      Enable = se[i];
      for (int l = 0; l < NL; l++) begin
        RxByte[8*l +: 8] = sb[l][i];
        RxControl[l]     = sk[l][i];
      end
      @(posedge Clk);
      #1;
    end
    RxByte    = '0;
    RxControl = '0;
    Enable    = 1'b1;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge Clk);
      #1;
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got no end of run, required completion");
    $fatal(1);
  end

  initial begin
    int   c0;
    logic probe;
    logic x_ok;

    notReset  = 1'b0;
    Enable    = 1'b1;
    RxByte    = '0;
    RxControl = '0;
    repeat (3) @(posedge Clk);
    @(negedge Clk);
    chk("reset TsValid", 64'(TsValid), 64'h0);
    chk("reset TsIsTs2", 64'(TsIsTs2), 64'h0);
    chk("reset TsLinkNum", 64'(TsLinkNum), 64'h0);
    chk("reset TsLaneNum/Nfts", 64'({TsLaneNum, TsNfts}), 64'h0);
    chk("reset TsRate/Ctrl", 64'({TsRate, TsCtrl}), 64'h0);
    chk("reset Skp/Fts/Eios", 64'({SkpSeen, FtsSeen, EiosSeen}), 64'h0);
    chk("reset SeenOS", 64'(SeenOS), 64'h0);
    chk("reset OsErr/XErr", 64'({OsErr, XErr}), 64'h0);
    chk("reset LinkMismatch", 64'(LinkMismatch), 64'h0);
    chk("reset ErrCount", 64'(ErrCount), 64'h0);
    notReset = 1'b1;
    @(posedge Clk);
    #1;

    // Lane 0 TS1
    clear_seq();
    put_ts(0, 0, 8'h01, 1'b0, 8'h00, 1'b0, 8'h1F, 8'h4A);
    c0 = cyc;
    push_ts(0, c0 + 16, 8'h01, 8'h00, 8'h1F, 1'b0);
    run_seq(16);
    idle(2);
    chk("TS1 ErrCount lane0", 64'(ErrCount[0 +: CW]), 64'h0);
    chk("TS1 SeenOS lane0", 64'(SeenOS[0]), 64'h1);

    // All lanes TS2 with PAD link and lane numbers: no mismatch
    clear_seq();
    for (int l = 0; l < NL; l++) begin
      put_ts(l, 0, 8'hF7, 1'b1, 8'hF7, 1'b1, 8'h10, 8'h45);
    end
    c0 = cyc;
    for (int l = 0; l < NL; l++) push_ts(l, c0 + 16, 8'hF7, 8'hF7, 8'h10, 1'b1);
    run_seq(16);
    @(negedge Clk);
    chk("PAD links LinkMismatch", 64'(LinkMismatch), 64'h0);
    @(posedge Clk);
    #1;
    idle(2);

    // Lanes 0/1 with different link numbers
    clear_seq();
    put_ts(0, 0, 8'h01, 1'b0, 8'h00, 1'b0, 8'h1F, 8'h4A);
    put_ts(1, 0, 8'h02, 1'b0, 8'h01, 1'b0, 8'h1F, 8'h4A);
    c0 = cyc;
    push_ts(0, c0 + 16, 8'h01, 8'h00, 8'h1F, 1'b0);
    push_ts(1, c0 + 16, 8'h02, 8'h01, 8'h1F, 1'b0);
    push_ev(K_MISM, 0, c0 + 17, '0, 1'b0);
    run_seq(16);
    idle(3);

    // Lane 0: COM at TS symbol 9 aborts, then a full TS1 follows
    clear_seq();
    put_ts(0, 0, 8'h01, 1'b0, 8'h00, 1'b0, 8'h1F, 8'h4A);
    put_ts(0, 9, 8'h03, 1'b0, 8'h00, 1'b0, 8'h22, 8'h4A);
    c0 = cyc;
    push_ev(K_OERR, 0, c0 + 10, 2'd1, 1'b0);
    push_ts(0, c0 + 25, 8'h03, 8'h00, 8'h22, 1'b0);
    run_seq(25);
    idle(2);
    chk("abort ErrCount lane0", 64'(ErrCount[0 +: CW]), 64'h1);

    // Lane 1 TS1 with Enable low for three cycles mid-body (garbage COMs ignored)
    clear_seq();
    put_ts(1, 0, 8'h05, 1'b0, 8'h01, 1'b0, 8'h20, 8'h4A);
    for (int p = 18; p >= 11; p--) put(1, p, sb[1][p-3], sk[1][p-3]);
    for (int p = 8; p <= 10; p++) begin
      put(1, p, 8'hBC, 1'b1);
      se[p] = 1'b0;
    end
    c0 = cyc;
    push_ts(1, c0 + 19, 8'h05, 8'h01, 8'h20, 1'b0);
    run_seq(19);
    idle(2);

    // Lane 2: SKP, EIOS and FTS ordered sets
    clear_seq();
    put(2, 0, 8'hBC, 1'b1);
    for (int p = 1; p < 4; p++) put(2, p, 8'h1C, 1'b1);
    put(2, 4, 8'hBC, 1'b1);
    for (int p = 5; p < 8; p++) put(2, p, 8'h7C, 1'b1);
    put(2, 8, 8'hBC, 1'b1);
    put(2, 9, 8'h3C, 1'b1);
    c0 = cyc;
    push_ev(K_SKP, 2, c0 + 4, '0, 1'b1);
    push_ev(K_EIOS, 2, c0 + 8, '0, 1'b1);
    push_ev(K_FTS, 2, c0 + 10, '0, 1'b1);
    run_seq(10);
    idle(2);
    chk("SKP/EIOS SeenOS lane2", 64'(SeenOS[2]), 64'h1);

    // X on lane 2 after a valid OS (only meaningful where the simulator keeps X)
    probe = 1'bx;
    x_ok  = $isunknown(probe);
    if (x_ok) begin
      c0 = cyc;
      push_ev(K_XERR, 2, c0 + 1, 2'd1, 1'b0);
      RxByte[16 +: 8] = 8'hxx;
      @(posedge Clk);
      #1;
      RxByte = '0;
      idle(2);
      chk("X SeenOS lane2", 64'(SeenOS[2]), 64'h0);
    end

    // Lane 3: five malformed TS (bad identifier) saturate a 2-bit counter
    clear_seq();
    for (int t = 0; t < 5; t++) begin
      put(3, 7*t, 8'hBC, 1'b1);
      put(3, 7*t + 1, 8'h01, 1'b0);
      put(3, 7*t + 2, 8'h00, 1'b0);
      put(3, 7*t + 3, 8'h1F, 1'b0);
      put(3, 7*t + 4, 8'h02, 1'b0);
      put(3, 7*t + 5, 8'h00, 1'b0);
      put(3, 7*t + 6, 8'h11, 1'b0);
    end
    c0 = cyc;
    for (int t = 0; t < 5; t++) begin
      push_ev(K_OERR, 3, c0 + 7*t + 7, (t < 2) ? CW'(t + 1) : CW'(3), 1'b0);
    end
    run_seq(35);
    idle(3);

    chk("final ErrCount lane3", 64'(ErrCount[3*CW +: CW]), 64'h3);
    chk("final ErrCount lane1", 64'(ErrCount[1*CW +: CW]), 64'h0);
    chk("final ErrCount lane2", 64'(ErrCount[2*CW +: CW]), x_ok ? 64'h1 : 64'h0);
    chk("final ErrCount lane0", 64'(ErrCount[0 +: CW]), 64'h1);

    foreach (exp_q[i]) begin
      n_cmp++;
      n_err++;
      $display("FAIL missing %s lane %0d: got no pulse, required one at cycle %0d",
               kname(exp_q[i].kind), exp_q[i].lane, exp_q[i].cyc);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/pcie_ts_lane_monitor.md
Name: pcie_ts_lane_monitor

Overview:
- Parametrised multi-lane Gen1/Gen2 ordered-set monitor for the display-link path.
- Takes per-lane decoded symbols (byte plus K flag) and, per lane, delineates TS1/TS2, SKP, FTS and EIOS ordered sets.
- Captures TS fields into registers and flags protocol errors: malformed OS, COM abort, X after sync, cross-lane link-number mismatch.
- Feeds the link-level display and checker logic; performs no 8b10b decode and no printing.

Parameters:
- NUM_LANES, 16, number of monitored lanes (1..32).
- CNT_W, 8, width of each per-lane saturating error counter.
- CHECK_X, 1, when 1 enables X detection on RxByte after a lane has seen a valid OS.

Ports:
- Clk  input  1  monitor clock, one symbol per lane per cycle.
- notReset  input  1  synchronous active-low reset.
- Enable  input  1  when low, all lane FSMs hold state and no pulses or counts occur.
- RxByte  input  8*NUM_LANES  decoded symbols; lane n at [8n+7:8n].
- RxControl  input  NUM_LANES  K-symbol flag per lane.
- TsValid  output  NUM_LANES  one-cycle pulse: complete TS captured.
- TsIsTs2  output  NUM_LANES  type of the last TS captured: 0 = TS1, 1 = TS2.
- TsLinkNum, TsLaneNum, TsNfts, TsRate, TsCtrl  output  8*NUM_LANES each  captured TS symbols 1..5; 8'hF7 means PAD.
- SkpSeen, FtsSeen, EiosSeen  output  NUM_LANES each  one-cycle pulses.
- SeenOS  output  NUM_LANES  sticky; set on any valid TS, SKP or FTS.
- OsErr  output  NUM_LANES  one-cycle error pulse.
- XErr  output  NUM_LANES  one-cycle pulse on X after SeenOS.
- LinkMismatch  output  1  one-cycle pulse.
- ErrCount  output  CNT_W*NUM_LANES  per-lane saturating error count.

Behaviour:
- Reset (notReset=0 at posedge Clk): every output 0, every FSM to HUNT, symbol index 0.
- Constants:
  - COM = K 8'hBC, PAD = K 8'hF7, SKP = K 8'h1C, FTS = K 8'h3C, IDL = K 8'h7C.
  - TS1 identifier D 8'h4A, TS2 identifier D 8'h45.
- Per-lane FSM states: HUNT, TS_BODY, SKP_BODY, EI_BODY. Idx is a 4-bit symbol index.
- HUNT:
  - On COM, Idx is set to 1.
  - The next symbol selects the branch: SKP -> SKP_BODY; FTS -> FtsSeen pulse at that symbol, back to HUNT; IDL -> EI_BODY; data or PAD -> TS_BODY, and that symbol is the link number.
- TS_BODY: symbols 1..15.
  - Symbols 1..2 may be PAD or data. Symbols 3..15 must be data (K=0).
  - Symbol 6 must be 4A or 45; symbols 7..15 must equal symbol 6.
  - Any violation: OsErr pulse, return to HUNT.
  - After a good symbol 15: on the next edge, TsValid pulses and fields latch together. Latency is one cycle after the last symbol.
  - Fields hold until the next TsValid.
- SKP_BODY: exactly 3 SKP symbols total after COM, then SkpSeen. Fewer than 3 followed by a non-SKP symbol: OsErr. Skip-count variation is not supported; it is a decided limitation.
- EI_BODY: 3 IDL symbols after COM, then EiosSeen.
- COM received mid-body: OsErr pulse for the aborted OS, and the COM starts a new OS (Idx=1). The same cycle does not return to HUNT.
- X detection (CHECK_X=1, SeenOS=1, ^RxByte lane === x):
  - XErr pulse, SeenOS cleared, FSM to HUNT.
  - This takes precedence over the OsErr decision in that cycle.
- ErrCount increments by 1 on each cycle with OsErr or XErr, and saturates at all-ones. If OsErr and XErr would both apply, only XErr fires and the count increments by 1.
- LinkMismatch: pulses one cycle after any cycle where two or more lanes have TsValid high together with differing non-PAD TsLinkNum values. Uses the post-latch fields.
- Enable low mid-OS: state is frozen and the OS resumes when Enable returns high.
- Reset mid-OS: discards the OS, no pulse.

Decomposition:
- Shared package pcie_mon_pkg holds:
  - symbol constants (COM, PAD, SKP, FTS, IDL, TS1_ID, TS2_ID);
  - TS offset constants (TSX_LINKNUM=1, TSX_LANENUM=2, TSX_N_FTS=3, TSX_DATARATE=4, TSX_LINKCONTROL=5, TSX_ID=6);
  - the lane state enum.
- One sub-module pcie_os_lane_fsm (single-lane FSM, field capture, counter), instantiated NUM_LANES times by generate.
- The top adds the mismatch comparator only.

Test Plan:
- Lane 0: COM, 8'h01, 8'h00, 8'h1F, 8'h02, 8'h00, 10×4A -> TsValid[0] one cycle after the last 4A; TsLinkNum=01, TsLaneNum=00, TsNfts=1F, TsRate=02, TsIsTs2=0; ErrCount=0.
- Lanes 0..3: TS2 with link PAD (K F7), lane PAD, ids 45 -> TsIsTs2=1 on all lanes, TsLinkNum=F7, LinkMismatch=0.
- Lanes 0/1: simultaneous TS1 with link 01 and 02 -> LinkMismatch pulse exactly one cycle after TsValid.
- COM at TS symbol 9, then a full valid TS1 -> OsErr at symbol 9, ErrCount=1, TsValid for the second TS.
- COM,SKP,SKP,SKP then COM,IDL,IDL,IDL -> SkpSeen and EiosSeen pulses, SeenOS=1; then drive 8'hxx -> XErr=1, SeenOS=0.
- ErrCount forced with CNT_W=2 and 5 malformed TS -> ErrCount holds at 3.
